rr_arbiter_4: RTL and testbench
===============================

RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

Interface
REQ-001 Parameter: MAX_HOLD, default 8, max cycles one grant is held before forced release (legal 1..15).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 req  input  4  request lines; bit i = requester i; level-sensitive.
REQ-005 done  input  1  granted requester releases its grant this cycle.
REQ-006 gnt  output  4  registered one-hot grant; all-zero when nothing granted.
REQ-007 gnt_id  output  2  binary index of granted requester; 0 when gnt_valid=0.
REQ-008 gnt_valid  output  1  high while any gnt bit is high.
REQ-009 timeout  output  1  one-cycle pulse flagging a MAX_HOLD forced release.

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE and GRANT.
REQ-011 Internal state SHALL be: 2-bit priority pointer ptr, 4-bit hold counter hold_cnt, FSM state.
REQ-012 In IDLE with req!=0 at edge N, winner SHALL be the first set req bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4); gnt/gnt_id/gnt_valid SHALL be driven at edge N, i.e. 1-cycle latency from req sampled to grant visible.
REQ-013 In IDLE with req==0, outputs SHALL stay zero and ptr SHALL not change.
REQ-014 On entering GRANT, hold_cnt SHALL load 0; each GRANT cycle without release SHALL increment hold_cnt.
REQ-015 In GRANT, release SHALL occur on the edge after a cycle where any of: done=1; req[gnt_id]=0; hold_cnt==MAX_HOLD-1.
REQ-016 A granted requester SHALL therefore hold gnt for at most MAX_HOLD cycles.
REQ-017 On release, FSM SHALL go to IDLE, gnt/gnt_id/gnt_valid SHALL clear, ptr SHALL load gnt_id+1 (mod 4, 3 wraps to 0).
REQ-018 After any release there SHALL be exactly one IDLE cycle with gnt_valid=0 before the next grant.
REQ-019 timeout SHALL pulse high for exactly the one cycle following a release caused solely by hold_cnt reaching MAX_HOLD-1.
REQ-020 If done=1 or req[gnt_id]=0 in the same cycle the hold limit is reached, release SHALL be normal and timeout SHALL stay 0.
REQ-021 done SHALL be ignored in IDLE; req changes on non-granted bits SHALL be ignored in GRANT.
REQ-022 gnt SHALL never have more than one bit set; gnt_valid SHALL equal |gnt in every cycle.

Reset
REQ-023 With rst_n=0 at a rising edge: state=IDLE, ptr=0, hold_cnt=0, gnt=0000, gnt_id=0, gnt_valid=0, timeout=0.
REQ-024 Reset asserted during GRANT SHALL drop the grant at that edge with no timeout pulse and ptr=0.
REQ-025 The first arbitration after reset release SHALL use ptr=0 (requester 0 highest priority).

Verification
REQ-026 Reset, req=1111 held, done=1 in 2nd cycle of each grant -> grant order 0,1,2,3,0, each 2 cycles, 1 idle cycle between.
REQ-027 Reset, req=0100 -> one edge later gnt=0100, gnt_id=2, gnt_valid=1; drop req -> next edge gnt=0000, ptr=3.
REQ-028 MAX_HOLD=8, req=0001 held, done=0 -> gnt=0001 for 8 cycles, timeout=1 for 1 cycle with gnt=0000, then gnt=0001 again.
REQ-029 MAX_HOLD=8, done=1 exactly in 8th grant cycle -> release, timeout stays 0.
REQ-030 ptr=3, req=1001 -> gnt_id=3 first; after release ptr=0, gnt_id=0 next (wrap-around).
REQ-031 rst_n=0 mid-grant (gnt=0010) -> next edge all outputs 0; after rst_n=1 with req=1010, gnt_id=1.

Source files
------------

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a bounded hold time.
// A grant is released on done, on the holder dropping its request, or when the hold limit is reached.
module rr_arbiter_4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout,
    output logic       dbg_state,
    output logic [1:0] dbg_ptr
);

    // Handshake: requester i holds req[i] high until it sees gnt[i]; it keeps the grant
    // while req[i] stays high, and gives it back by pulsing done or dropping req[i].
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [3:0] hold_cnt;
    logic [1:0] win_id;
    logic       win_found;
    logic [1:0] cand;
    logic       hold_limit;
    logic       release_now;

    always_comb begin
        win_id    = ptr;
        win_found = 1'b0;
        cand      = ptr;
        for (int i = 0; i < 4; i++) begin
            cand = ptr + 2'(i);
            if (!win_found && req[cand]) begin
                win_id    = cand;
                win_found = 1'b1;
            end
        end
    end

    assign hold_limit  = (hold_cnt == 4'(MAX_HOLD - 1));
    assign release_now = done || !req[gnt_id] || hold_limit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            hold_cnt  <= 4'd0;
            gnt       <= 4'b0000;
            gnt_id    <= 2'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    timeout <= 1'b0;
                    if (win_found) begin
                        state     <= GRANT;
                        hold_cnt  <= 4'd0;
                        gnt       <= 4'b0001 << win_id;
                        gnt_id    <= win_id;
                        gnt_valid <= 1'b1;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state     <= IDLE;
                        ptr       <= gnt_id + 2'd1;
                        hold_cnt  <= 4'd0;
                        gnt       <= 4'b0000;
                        gnt_id    <= 2'd0;
                        gnt_valid <= 1'b0;
                        // Only a release forced purely by the hold limit is flagged.
                        timeout   <= hold_limit && !done && req[gnt_id];
                    end else begin
                        hold_cnt <= hold_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg_state = (state == GRANT);
    assign dbg_ptr   = ptr;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4: directed scenarios with an expected-output queue
// plus a randomized run checking grant invariants.
module tb_rr_arbiter_4;

    localparam int MAX_HOLD = 8;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;
    logic       dbg_state;
    logic [1:0] dbg_ptr;

    logic [7:0] exp_q[$];
    int         tests_run = 0;
    int         fails = 0;

    localparam logic [7:0] IDLE_E = 8'h00;
    localparam logic [7:0] TO_E   = 8'h01;

    rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .timeout(timeout),
        .dbg_state(dbg_state), .dbg_ptr(dbg_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {gnt, gnt_id, gnt_valid, timeout} while requester id holds the grant.
    function automatic logic [7:0] g(input int id);
        return {4'(1 << id), 2'(id), 2'b10};
    endfunction

    function automatic logic [7:0] obs();
        return {gnt, gnt_id, gnt_valid, timeout};
    endfunction

    task automatic drive(input logic r, input logic [3:0] rq, input logic d, input logic [7:0] e);
        rst_n = r;
        req   = rq;
        done  = d;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] e;
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 4'hF, 1'b1, IDLE_E);
            e = exp_q.pop_front();
            tests_run++;
            if (obs() !== e) begin
                fails++;
                $display("FAIL reset[%0d]: got %h required %h", k, obs(), e);
            end
        end
        tests_run++;
        if (dbg_ptr !== 2'd0 || dbg_state !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: got ptr=%0d state=%0d required ptr=0 state=0", dbg_ptr, dbg_state);
        end
    endtask

    task automatic test_rotation();
        logic [7:0] e;
        int         ids[5] = '{0, 1, 2, 3, 0};
        drive(1'b0, 4'h0, 1'b0, IDLE_E);
        void'(exp_q.pop_front());
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 3; c++) begin
                // done is high in the idle cycle too, where it must be ignored
                drive(1'b1, 4'hF, (c != 1), (c == 2) ? IDLE_E : g(ids[k]));
                e = exp_q.pop_front();
                tests_run++;
                if (obs() !== e) begin
                    fails++;
                    $display("FAIL rotation[%0d.%0d]: got %h required %h", k, c, obs(), e);
                end
            end
        end
    endtask

    task automatic test_single();
        logic [7:0] e;
        logic [3:0] rq_t[4] = '{4'h0, 4'h4, 4'h0, 4'h0};
        logic [7:0] e_t[4]  = '{IDLE_E, g(2), IDLE_E, IDLE_E};
        for (int k = 0; k < 4; k++) begin
            drive((k != 0), rq_t[k], 1'b0, e_t[k]);
            e = exp_q.pop_front();
            tests_run++;
            if (obs() !== e) begin
                fails++;
                $display("FAIL single[%0d]: got %h required %h", k, obs(), e);
            end
            if (k >= 2) begin
                tests_run++;
                if (dbg_ptr !== 2'd3) begin
                    fails++;
                    $display("FAIL single_ptr[%0d]: got %0d required 3", k, dbg_ptr);
                end
            end
        end
    endtask

    task automatic test_timeout();
        logic [7:0] e;
        drive(1'b0, 4'h0, 1'b0, IDLE_E);
        void'(exp_q.pop_front());
        for (int k = 1; k <= MAX_HOLD + 3; k++) begin
            drive(1'b1, 4'h1, 1'b0, (k == MAX_HOLD + 1) ? TO_E : g(0));
            e = exp_q.pop_front();
            tests_run++;
            if (obs() !== e) begin
                fails++;
                $display("FAIL timeout[%0d]: got %h required %h", k, obs(), e);
            end
        end
    endtask

    // Hold limit coinciding with done (v=0) or with the request dropping (v=1).
    task automatic test_limit_release();
        logic [7:0] e;
        logic [3:0] rq;
        logic       d;
        for (int v = 0; v < 2; v++) begin
            drive(1'b0, 4'h0, 1'b0, IDLE_E);
            void'(exp_q.pop_front());
            for (int k = 1; k <= MAX_HOLD + 2; k++) begin
                rq = (v == 1 && k > MAX_HOLD) ? 4'h0 : 4'h1;
                d  = (v == 0 && k == MAX_HOLD + 1);
                if (k == MAX_HOLD + 1)      e = IDLE_E;
                else if (k == MAX_HOLD + 2) e = (v == 0) ? g(0) : IDLE_E;
                else                        e = g(0);
                drive(1'b1, rq, d, e);
                e = exp_q.pop_front();
                tests_run++;
                if (obs() !== e) begin
                    fails++;
                    $display("FAIL limit_release[v%0d.%0d]: got %h required %h", v, k, obs(), e);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] e;
        logic [3:0] rq_t[6] = '{4'h0, 4'h4, 4'h0, 4'h9, 4'h9, 4'h9};
        logic       d_t[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [7:0] e_t[6]  = '{IDLE_E, g(2), IDLE_E, g(3), IDLE_E, g(0)};
        for (int k = 0; k < 6; k++) begin
            drive((k != 0), rq_t[k], d_t[k], e_t[k]);
            e = exp_q.pop_front();
            tests_run++;
            if (obs() !== e) begin
                fails++;
                $display("FAIL wrap[%0d]: got %h required %h", k, obs(), e);
            end
            if (k == 4) begin
                tests_run++;
                if (dbg_ptr !== 2'd0) begin
                    fails++;
                    $display("FAIL wrap_ptr: got %0d required 0", dbg_ptr);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] e;
        logic       r_t[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [3:0] rq_t[5] = '{4'h0, 4'h2, 4'h2, 4'h2, 4'hA};
        logic [7:0] e_t[5]  = '{IDLE_E, g(1), g(1), IDLE_E, g(1)};
        for (int k = 0; k < 5; k++) begin
            drive(r_t[k], rq_t[k], 1'b0, e_t[k]);
            e = exp_q.pop_front();
            tests_run++;
            if (obs() !== e) begin
                fails++;
                $display("FAIL reset_mid[%0d]: got %h required %h", k, obs(), e);
            end
        end
    endtask

    task automatic test_ignore_others();
        logic [7:0] e;
        logic [3:0] rq_t[6] = '{4'h0, 4'h3, 4'hF, 4'h1, 4'hE, 4'hE};
        logic [7:0] e_t[6]  = '{IDLE_E, g(0), g(0), g(0), IDLE_E, g(1)};
        for (int k = 0; k < 6; k++) begin
            drive((k != 0), rq_t[k], 1'b0, e_t[k]);
            e = exp_q.pop_front();
            tests_run++;
            if (obs() !== e) begin
                fails++;
                $display("FAIL ignore_others[%0d]: got %h required %h", k, obs(), e);
            end
        end
    endtask

    task automatic test_random();
        int         run = 0;
        logic       prev_valid = 1'b0;
        logic [3:0] prev_gnt = 4'h0;
        drive(1'b0, 4'h0, 1'b0, IDLE_E);
        void'(exp_q.pop_front());
        for (int k = 0; k < 400; k++) begin
            rst_n = 1'b1;
            req   = 4'($urandom_range(0, 15));
            done  = ($urandom_range(0, 9) == 0);
            @(posedge clk);
            #1;
            run = gnt_valid ? run + 1 : 0;
            tests_run++;
            if ($countones(gnt) > 1 || gnt_valid !== (|gnt) ||
                (gnt_valid && gnt !== (4'b0001 << gnt_id)) || (!gnt_valid && gnt_id !== 2'd0)) begin
                fails++;
                $display("FAIL random_onehot[%0d]: got gnt=%b id=%0d valid=%b required consistent one-hot", k, gnt, gnt_id, gnt_valid);
            end
            tests_run++;
            if (run > MAX_HOLD || (prev_valid && gnt_valid && gnt !== prev_gnt) || (timeout && gnt_valid)) begin
                fails++;
                $display("FAIL random_hold[%0d]: got run=%0d gnt=%b prev=%b timeout=%b required run<=%0d and idle gap", k, run, gnt, prev_gnt, timeout, MAX_HOLD);
            end
            prev_valid = gnt_valid;
            prev_gnt   = gnt;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'h0;
        done  = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_rotation();
        test_single();
        test_timeout();
        test_limit_release();
        test_wrap();
        test_reset_mid();
        test_ignore_others();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
